// File: rtl/serial_alu_seq_if.sv
// Operation/result bundle for the bit-serial ALU sequencer: request, operands,
// handshake status and the registered result with its flags.
interface serial_alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [2:0]       cntrl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output start, cntrl, A, B,
        input  busy, done, result, negative, zero, overflow, carry_out
    );

    modport slave (
        input  start, cntrl, A, B,
        output busy, done, result, negative, zero, overflow, carry_out
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: one 1-bit ALU slice iterated LSB first over WIDTH
// clocks, with carry and zero chains closed through registers.
module serial_alu_seq #(
    parameter int WIDTH = 64
) (
    input logic            clk,
    input logic            reset,
    serial_alu_seq_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             zero_acc_q, zero_acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             negative_q, negative_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             carry_out_q, carry_out_d;

    logic             a_bit_s, b_bit_s, b_eff_s, sum_s, cout_s, slice_s;
    logic             is_arith_s, last_s, zero_next_s;
    logic [WIDTH-1:0] res_next_s;

    // One-bit ALU slice plus next-state computation for the sequencer.
    always_comb begin
        a_bit_s     = a_sh_q[0];
        b_bit_s     = b_sh_q[0];
        b_eff_s     = b_bit_s ^ op_q[0];
        sum_s       = a_bit_s ^ b_eff_s ^ carry_q;
        cout_s      = (a_bit_s & b_eff_s) | (a_bit_s & carry_q) | (b_eff_s & carry_q);
        is_arith_s  = (op_q[2:1] == 2'b01);
        last_s      = (cnt_q == CW'(WIDTH - 1));

        case (op_q)
            3'b000:         slice_s = b_bit_s;
            3'b010, 3'b011: slice_s = sum_s;
            3'b100:         slice_s = a_bit_s & b_bit_s;
            3'b101:         slice_s = a_bit_s | b_bit_s;
            3'b110:         slice_s = a_bit_s ^ b_bit_s;
            default:        slice_s = 1'b0;
        endcase

        res_next_s  = {slice_s, res_sh_q[WIDTH-1:1]};
        zero_next_s = zero_acc_q & ~slice_s;

        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        op_d        = op_q;
        carry_d     = carry_q;
        zero_acc_d  = zero_acc_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        negative_d  = negative_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        carry_out_d = carry_out_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d     = bus.A;
                    b_sh_d     = bus.B;
                    op_d       = bus.cntrl;
                    carry_d    = bus.cntrl[0];
                    zero_acc_d = 1'b1;
                    cnt_d      = {CW{1'b0}};
                    res_sh_d   = {WIDTH{1'b0}};
                    busy_d     = 1'b1;
                    state_d    = S_RUN;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d     = a_sh_q >> 1;
                b_sh_d     = b_sh_q >> 1;
                res_sh_d   = res_next_s;
                carry_d    = cout_s;
                zero_acc_d = zero_next_s;
                cnt_d      = cnt_q + CW'(1);
                // On the MSB, carry_q is still the carry into that bit, so the
                // overflow term needs no separate capture register.
                if (last_s) begin
                    state_d    = S_IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    result_d   = res_next_s;
                    negative_d = res_next_s[WIDTH-1];
                    zero_d     = zero_next_s;
                    if (is_arith_s) begin
                        carry_out_d = cout_s;
                        overflow_d  = carry_q ^ cout_s;
                    end else begin
                        carry_out_d = 1'b0;
                        overflow_d  = 1'b0;
                    end
                end else begin
                    state_d    = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state, shift registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_sh_q      <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            res_sh_q    <= {WIDTH{1'b0}};
            op_q        <= 3'b000;
            carry_q     <= 1'b0;
            zero_acc_q  <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            negative_q  <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            zero_acc_q  <= zero_acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            negative_q  <= negative_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.negative  = negative_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.carry_out = carry_out_q;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq: directed table, handshake and reset
// sequences, and random operations against an arithmetic reference model.
module tb_serial_alu_seq;
    localparam int W = 64;

    typedef struct {
        logic [W-1:0] r;
        logic         n;
        logic         z;
        logic         v;
        logic         c;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    serial_alu_seq_if #(.WIDTH(W)) bus ();

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic n, input logic z,
                                input logic v, input logic c);
        exp_t e;
        e.r = r; e.n = n; e.z = z; e.v = v; e.c = c;
        return e;
    endfunction

    // Reference model from plain arithmetic on whole words.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] wide;
        e.r = '0; e.v = 1'b0; e.c = 1'b0;
        case (op)
            3'b000: e.r = b;
            3'b010: begin
                wide = {1'b0, a} + {1'b0, b};
                e.r  = wide[W-1:0];
                e.c  = wide[W];
                e.v  = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'b011: begin
                e.r = a - b;
                e.c = (a >= b);
                e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'b100: e.r = a & b;
            3'b101: e.r = a | b;
            3'b110: e.r = a ^ b;
            default: e.r = '0;
        endcase
        e.n = e.r[W-1];
        e.z = (e.r == '0);
        return e;
    endfunction

    // Issue one op (called at a negedge) and check latency, holding and outputs.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t e, input bit inject);
        logic [W-1:0] snap_r;
        logic [3:0]   snap_f;
        int           lat, unstable, busy_bad;
        lat = -1; unstable = 0; busy_bad = 0;
        snap_r = bus.result;
        snap_f = {bus.negative, bus.zero, bus.overflow, bus.carry_out};
        bus.start = 1'b1; bus.cntrl = op; bus.A = a; bus.B = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check({nm, " busy0"}, 64'(bus.busy), 64'd1);
        check({nm, " done0"}, 64'(bus.done), 64'd0);
        for (int j = 1; j <= W + 8; j++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = j;
                break;
            end
            if (bus.result !== snap_r || {bus.negative, bus.zero, bus.overflow, bus.carry_out} !== snap_f)
                unstable++;
            if (bus.busy !== 1'b1) busy_bad++;
            if (inject && j == 20) begin
                bus.start = 1'b1; bus.cntrl = 3'b011; bus.A = 64'd9; bus.B = 64'd4;
            end else if (inject && j == 21) begin
                bus.start = 1'b0; bus.A = a; bus.B = b; bus.cntrl = op;
            end
        end
        bus.start = 1'b0;
        check({nm, " latency"}, 64'(lat), 64'(W));
        check({nm, " hold"}, 64'(unstable), 64'd0);
        check({nm, " busy_run"}, 64'(busy_bad), 64'd0);
        check({nm, " busy_done"}, 64'(bus.busy), 64'd0);
        check({nm, " result"}, bus.result, e.r);
        check({nm, " flags nzvc"}, 64'({bus.negative, bus.zero, bus.overflow, bus.carry_out}),
              64'({e.n, e.z, e.v, e.c}));
    endtask

    vec_t tbl[11];

    initial begin
        int          done_seen;
        logic [2:0]  rop;
        logic [W-1:0] ra, rb;
        n_checks = 0; n_fail = 0;
        bus.start = 1'b0; bus.cntrl = 3'b000; bus.A = '0; bus.B = '0;

        tbl[0]  = '{3'b010, 64'd5, 64'd7, mk(64'd12, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[1]  = '{3'b011, 64'd3, 64'd5, mk(64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[2]  = '{3'b011, 64'd5, 64'd5, mk(64'd0, 1'b0, 1'b1, 1'b0, 1'b1)};
        tbl[3]  = '{3'b010, 64'h7FFFFFFFFFFFFFFF, 64'd1, mk(64'h8000000000000000, 1'b1, 1'b0, 1'b1, 1'b0)};
        tbl[4]  = '{3'b010, 64'hFFFFFFFFFFFFFFFF, 64'd1, mk(64'd0, 1'b0, 1'b1, 1'b0, 1'b1)};
        tbl[5]  = '{3'b100, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, mk(64'hF000F000F000F000, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[6]  = '{3'b101, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, mk(64'hFFF0FFF0FFF0FFF0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[7]  = '{3'b110, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, mk(64'h0FF00FF00FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[8]  = '{3'b000, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, mk(64'hFF00FF00FF00FF00, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[9]  = '{3'b111, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, mk(64'd0, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[10] = '{3'b001, 64'd5, 64'd3, mk(64'd0, 1'b0, 1'b1, 1'b0, 1'b0)};

        reset = 1'b1;
        #3;
        check("reset result", bus.result, 64'd0);
        check("reset ctl bnzvcd", 64'({bus.busy, bus.negative, bus.zero, bus.overflow, bus.carry_out, bus.done}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e, 1'b0);

        // Start during RUN is ignored; start in the done cycle is accepted.
        run_op("hs_add", 3'b010, 64'd1, 64'd1, mk(64'd2, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        run_op("hs_b2b", 3'b011, 64'd9, 64'd4, mk(64'd5, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);

        // Asynchronous reset in the middle of an operation.
        bus.start = 1'b1; bus.cntrl = 3'b010; bus.A = 64'd100; bus.B = 64'd200;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst result", bus.result, 64'd0);
        check("midrst ctl bnzvcd", 64'({bus.busy, bus.negative, bus.zero, bus.overflow, bus.carry_out, bus.done}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int j = 0; j < W + 8; j++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("midrst no_done", 64'(done_seen), 64'd0);
        run_op("post_rst", 3'b010, 64'd100, 64'd200, mk(64'd300, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);

        for (int k = 0; k < 24; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) rb = ra;
            if ($urandom_range(0, 4) == 0) ra = 64'h7FFFFFFFFFFFFFFF;
            if ($urandom_range(0, 4) == 0) rb = 64'h8000000000000000;
            run_op($sformatf("rnd%0d op%0d", k, rop), rop, ra, rb, model(rop, ra, rb), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Bit-serial 64-bit ALU sequencer. It closes the carry and zero chains around a single one-bit ALU slice and processes one bit per clock, LSB first.
- It accepts one operation through a start/busy/done handshake. It returns a registered result plus negative/zero/overflow/carry_out flags.
- It uses the same cntrl encoding as the parallel ALU and is a drop-in area-saving alternative for multi-cycle datapaths.

Parameters:
WIDTH, 64, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
cntrl  input  3  operation: 000 B, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 A^B
A  input  WIDTH  operand A, captured on accepted start
B  input  WIDTH  operand B, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result/flags update
result  output  WIDTH  registered result
negative  output  1  result[WIDTH-1]
zero  output  1  result == 0
overflow  output  1  signed overflow (add/sub only, else 0)
carry_out  output  1  carry out of MSB (add/sub only, else 0)

Behaviour:
- States: IDLE, RUN.
- Reset (async, any state, including mid-RUN):
  - state = IDLE.
  - busy, done, result, negative, zero, overflow, carry_out = 0.
  - Internal registers cleared; the in-flight operation is discarded with no done pulse.
- IDLE, start=1 at clock edge k:
  - Latch A, B, cntrl into internal shift/op registers.
  - carry_reg = cntrl[0] (1 for subtract; don't-care for logic ops).
  - zero_reg = 1; bit counter = 0.
  - Go to RUN; busy=1 from edge k.
- RUN, each cycle, current bit i = A_sh[0], B_sh[0]:
  - b' = B_bit XOR cntrl[0].
  - sum = A^b'^carry_reg; cout = majority(A, b', carry_reg).
  - slice_out by cntrl:
    - 000 → B_bit (un-inverted)
    - 01x → sum
    - 100 → A&B
    - 101 → A|B
    - 110 → A^B
    - 001, 111 → 0
  - Shift slice_out into the MSB of the result shift register (right shift); shift A_sh and B_sh right.
  - carry_reg <= cout; zero_reg <= zero_reg & ~slice_out.
  - When i == WIDTH-1, also capture carry_in_msb = carry_reg.
  - Counter increments; after bit WIDTH-1 is processed (edge k+WIDTH), go to IDLE.
- Completion (edge k+WIDTH):
  - result <= full shifted word; negative <= its MSB; zero <= final zero_reg.
  - For cntrl 010/011: carry_out <= final cout; overflow <= carry_in_msb XOR final cout. For all other cntrl: carry_out = overflow = 0.
  - done=1 for exactly the one cycle following edge k+WIDTH; busy=0 in that same cycle.
- Latency: done high WIDTH edges after the accepting edge (64 for default).
- Output holding: result and flags hold their values between completions and do not change during RUN.
- start while busy: ignored, no queueing, operands not re-latched.
- start in the done cycle: state is IDLE, so it is accepted (back-to-back throughput = WIDTH cycles per op).
- Undefined cntrl (001, 111): result 0, zero=1, negative=0, overflow=0, carry_out=0.
- Subtract carry convention: carry_out=1 means no borrow (A >= B unsigned).

Test Plan:
1. ADD A=5, B=7, start pulse → done exactly 64 cycles after accepting edge; result=12; negative=0, zero=0, overflow=0, carry_out=0; busy high 64 cycles.
2. SUB A=3, B=5 → result=0xFFFFFFFFFFFFFFFE, negative=1, carry_out=0, overflow=0. Then SUB A=5, B=5 → result=0, zero=1, carry_out=1, overflow=0.
3. ADD A=0x7FFFFFFFFFFFFFFF, B=1 → result=0x8000000000000000, overflow=1, negative=1, carry_out=0. Also ADD A=0xFFFFFFFFFFFFFFFF, B=1 → result=0, zero=1, carry_out=1, overflow=0.
4. Logic/pass ops with A=0xF0F0F0F0F0F0F0F0, B=0xFF00FF00FF00FF00:
   - AND → 0xF000F000F000F000
   - OR → 0xFFF0FFF0FFF0FFF0
   - XOR → 0x0FF00FF00FF00FF0
   - cntrl 000 → 0xFF00FF00FF00FF00
   - Each with overflow=carry_out=0. Then cntrl 111 → result 0, zero=1.
5. Handshake checks:
   - Start ADD 1+1, then pulse start with SUB 9-4 at cycle 20 of RUN → ignored; result=2.
   - Start SUB 9-4 in the done cycle → accepted; result=5 exactly 64 cycles later.
   - result/flags stable throughout both RUN periods.
6. Reset mid-operation:
   - Start ADD 100+200; assert reset asynchronously (between edges) at bit 30 → busy, done, result, flags go 0 immediately; no done pulse afterwards.
   - Release reset; ADD 100+200 → result=300 after 64 cycles.
